// File: rtl/note_div_calc_if.sv
// Tone-frequency in / note_gen divider-value out bundle for note_div_calc.
// The master drives the raw frequencies and octave; the slave returns the dividers.
interface note_div_calc_if #(
    parameter int unsigned OUT_W = 22
);
    logic [31:0]      freqL;
    logic [31:0]      freqR;
    logic [2:0]       octave;
    logic [OUT_W-1:0] freq_outL;
    logic [OUT_W-1:0] freq_outR;
    logic             update;
    logic             busy;

    modport master (
        output freqL, freqR, octave,
        input  freq_outL, freq_outR, update, busy
    );

    modport slave (
        input  freqL, freqR, octave,
        output freq_outL, freq_outR, update, busy
    );
endinterface

// File: rtl/note_div_calc.sv
// Time-multiplexed restoring divider producing DIVIDEND/freq for both channels.
// Each round: sample inputs, divide left, divide right, commit both outputs at once.
module note_div_calc #(
    parameter int unsigned DIVIDEND   = 100_000_000,
    parameter int unsigned DIVIDEND_W = 27,
    parameter int unsigned OUT_W      = 22,
    parameter int unsigned SILENCE    = 100_000_000
) (
    input  logic           clk,
    input  logic           rst,
    note_div_calc_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] DIVIDEND_V = DIVIDEND_W'(DIVIDEND);
    localparam logic [CNT_W-1:0]      CNT_TOP    = CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] Q_MAX      = DIVIDEND_W'((64'd1 << OUT_W) - 64'd1);
    localparam logic [OUT_W-1:0]      OUT_MAX    = OUT_W'((64'd1 << OUT_W) - 64'd1);
    localparam logic [OUT_W-1:0]      OUT_SILENT = OUT_W'(1);

    typedef enum logic [1:0] {
        S_SAMPLE,
        S_DIV_L,
        S_DIV_R,
        S_COMMIT
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [32:0]           rem_q, rem_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVIDEND_W-1:0] quot_l_q, quot_l_d;
    logic [31:0]           freq_l_q, freq_l_d;
    logic [31:0]           freq_r_q, freq_r_d;
    logic [2:0]            oct_q, oct_d;
    logic [OUT_W-1:0]      out_l_q, out_l_d;
    logic [OUT_W-1:0]      out_r_q, out_r_d;
    logic                  update_q, update_d;
    logic                  busy_q, busy_d;

    logic [32:0]           div_l, div_r, div_sel;
    logic                  sil_l, sil_r;
    logic [33:0]           trial;
    logic                  ge;
    logic [32:0]           step_rem;
    logic [DIVIDEND_W-1:0] step_quot;

    // Octave scaling; doubling saturates so the divisor always fits in 32 bits.
    function automatic logic [32:0] eff_div(input logic [31:0] f, input logic [2:0] oct);
        logic [32:0] dbl;
        dbl = {f, 1'b0};
        case (oct)
            3'd1:    return {2'b00, f[31:1]};
            3'd3:    return dbl[32] ? 33'h0_FFFF_FFFF : dbl;
            default: return {1'b0, f};
        endcase
    endfunction

    function automatic logic [OUT_W-1:0] clip(input logic [DIVIDEND_W-1:0] q, input logic sil);
        if (sil)        return OUT_SILENT;
        if (q > Q_MAX)  return OUT_MAX;
        return q[OUT_W-1:0];
    endfunction

    assign div_l   = eff_div(freq_l_q, oct_q);
    assign div_r   = eff_div(freq_r_q, oct_q);
    assign sil_l   = (freq_l_q == 32'(SILENCE)) || (div_l == 33'd0);
    assign sil_r   = (freq_r_q == 32'(SILENCE)) || (div_r == 33'd0);
    assign div_sel = (state_q == S_DIV_R) ? div_r : div_l;

    // One restoring-division step, shared by both channels.
    assign trial     = {rem_q, DIVIDEND_V[cnt_q]};
    assign ge        = trial >= {1'b0, div_sel};
    assign step_rem  = ge ? (trial[32:0] - div_sel) : trial[32:0];
    assign step_quot = {quot_q[DIVIDEND_W-2:0], ge};

    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        quot_l_d = quot_l_q;
        freq_l_d = freq_l_q;
        freq_r_d = freq_r_q;
        oct_d    = oct_q;
        out_l_d  = out_l_q;
        out_r_d  = out_r_q;
        update_d = 1'b0;
        busy_d   = 1'b1;

        case (state_q)
            S_SAMPLE: begin
                freq_l_d = bus.freqL;
                freq_r_d = bus.freqR;
                oct_d    = bus.octave;
                cnt_d    = CNT_TOP;
                rem_d    = '0;
                quot_d   = '0;
                state_d  = S_DIV_L;
            end
            S_DIV_L: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quot_l_d = step_quot;
                    rem_d    = '0;
                    quot_d   = '0;
                    cnt_d    = CNT_TOP;
                    state_d  = S_DIV_R;
                end
            end
            S_DIV_R: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = CNT_TOP;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                out_l_d  = clip(quot_l_q, sil_l);
                out_r_d  = clip(quot_q, sil_r);
                update_d = 1'b1;
                state_d  = S_SAMPLE;
            end
            default: state_d = S_SAMPLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    // NOTE: the datapath registers are plain flops, not memories, so they are reset like the control state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_SAMPLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            quot_l_q <= '0;
            freq_l_q <= '0;
            freq_r_q <= '0;
            oct_q    <= '0;
            out_l_q  <= OUT_SILENT;
            out_r_q  <= OUT_SILENT;
            update_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            quot_l_q <= quot_l_d;
            freq_l_q <= freq_l_d;
            freq_r_q <= freq_r_d;
            oct_q    <= oct_d;
            out_l_q  <= out_l_d;
            out_r_q  <= out_r_d;
            update_q <= update_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.freq_outL = out_l_q;
    assign bus.freq_outR = out_r_q;
    assign bus.update    = update_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_note_div_calc.sv
// Directed and randomized bench for note_div_calc against an arithmetic reference model.
module tb_note_div_calc;
    localparam int unsigned OUT_W = 22;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;
    logic [31:0] fl, fr;
    logic [2:0]  oc;
    logic [OUT_W-1:0] prev_l, prev_r;

    note_div_calc_if #(.OUT_W(OUT_W)) bus ();

    note_div_calc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: floor(1e8 / scaled freq), silence -> 1, clipped to 22 bits.
    function automatic logic [OUT_W-1:0] ref_div(input logic [31:0] f, input logic [2:0] oct);
        longint unsigned eff;
        longint unsigned q;
        if (f == 32'd100_000_000) return OUT_W'(1);
        if (oct == 3'd1)      eff = longint'(f) / 2;
        else if (oct == 3'd3) eff = longint'(f) * 2;
        else                  eff = longint'(f);
        if (eff > 64'hFFFF_FFFF) eff = 64'hFFFF_FFFF;
        if (eff == 0) return OUT_W'(1);
        q = 64'd100_000_000 / eff;
        if (q > 64'd4194303) q = 64'd4194303;
        return OUT_W'(q);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts rising edges until update is seen high at a falling edge (bounded).
    task automatic wait_update(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (bus.update !== 1'b1 && cycles < 200);
        check("update_seen", {63'd0, bus.update}, 64'd1);
    endtask

    task automatic drive(input logic [31:0] l, input logic [31:0] r, input logic [2:0] o);
        bus.freqL  = l;
        bus.freqR  = r;
        bus.octave = o;
    endtask

    task automatic round_check(input string tag, input logic [31:0] l, input logic [31:0] r,
                               input logic [2:0] o);
        int c;
        drive(l, r, o);
        wait_update(c);
        check({tag, "_period"}, 64'(c), 64'd56);
        check({tag, "_L"}, 64'(bus.freq_outL), 64'(ref_div(l, o)));
        check({tag, "_R"}, 64'(bus.freq_outR), 64'(ref_div(r, o)));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset state
        rst = 1'b0;
        drive($urandom, $urandom, 3'($urandom));
        repeat (3) @(negedge clk);
        check("rst_outL", 64'(bus.freq_outL), 64'd1);
        check("rst_outR", 64'(bus.freq_outR), 64'd1);
        check("rst_update", {63'd0, bus.update}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);

        // First update exactly 56 edges after release
        drive(32'd262, 32'd262, 3'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_release", {63'd0, bus.busy}, 64'd1);
        wait_update(cyc);
        check("first_update_cycles", 64'(cyc + 1), 64'd56);
        check("oct2_L", 64'(bus.freq_outL), 64'(ref_div(32'd262, 3'd2)));
        check("oct2_R", 64'(bus.freq_outR), 64'(ref_div(32'd262, 3'd2)));
        @(negedge clk);
        check("update_one_cycle", {63'd0, bus.update}, 64'd0);
        wait_update(cyc);
        check("second_update_cycles", 64'(cyc + 1), 64'd56);

        // Octave scaling, silence, degenerate and saturation cases
        round_check("oct3", 32'd262, 32'd262, 3'd3);
        round_check("oct1", 32'd262, 32'd262, 3'd1);
        round_check("silence_oct3", 32'd100_000_000, 32'd5000, 3'd3);
        round_check("zero_R", 32'd523, 32'd0, 3'd2);
        round_check("one_oct1", 32'd440, 32'd1, 3'd1);
        round_check("sat_L", 32'd4, 32'd1000, 3'd2);
        round_check("ovf_R", 32'd7, 32'hFFFF_FFFF, 3'd3);
        round_check("oct7", 32'd1000, 32'd99_999_999, 3'd7);

        // Randomized rounds
        for (int i = 0; i < 10; i++) begin
            fl = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(1, 20000));
            fr = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(1, 20000));
            oc = 3'($urandom_range(0, 7));
            round_check("rand", fl, fr, oc);
        end

        // Input isolation and output hold mid-round
        round_check("pre_iso", 32'd1000, 32'd2000, 3'd2);
        prev_l = bus.freq_outL;
        prev_r = bus.freq_outR;
        drive(32'd262, 32'd262, 3'd2);
        repeat (10) @(negedge clk);
        bus.freqL = 32'd523;
        repeat (20) @(negedge clk);
        check("hold_L", 64'(bus.freq_outL), 64'(prev_l));
        check("hold_R", 64'(bus.freq_outR), 64'(prev_r));
        check("hold_update", {63'd0, bus.update}, 64'd0);
        wait_update(cyc);
        check("iso_cur_L", 64'(bus.freq_outL), 64'(ref_div(32'd262, 3'd2)));
        wait_update(cyc);
        check("iso_next_L", 64'(bus.freq_outL), 64'(ref_div(32'd523, 3'd2)));

        // Reset 20 cycles into the right-channel division
        drive(32'd330, 32'd440, 3'd2);
        repeat (48) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_outL", 64'(bus.freq_outL), 64'd1);
        check("midrst_outR", 64'(bus.freq_outR), 64'd1);
        check("midrst_update", {63'd0, bus.update}, 64'd0);
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        repeat (2) @(negedge clk);
        drive(32'd262, 32'd523, 3'd3);
        rst = 1'b1;
        wait_update(cyc);
        check("midrst_restart_cycles", 64'(cyc), 64'd56);
        check("midrst_L", 64'(bus.freq_outL), 64'(ref_div(32'd262, 3'd3)));
        check("midrst_R", 64'(bus.freq_outR), 64'(ref_div(32'd523, 3'd3)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
